// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, FSM state type and request checks for the SRAM slave
// and the DRAM-facing master adapter.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_DATA  = 3'd1,
    ST_W_RESP  = 3'd2,
    ST_R_ISSUE = 3'd3,
    ST_R_WAIT  = 3'd4,
    ST_R_DATA  = 3'd5
  } state_e;

  // Only full-word transfers with FIXED or INCR bursts are served.
  function automatic logic addr_error(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_4B) || (burst == BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_beat_ctr.sv
// Burst beat counter: tracks the current SRAM word address and flags the
// final beat of a burst.
module axi_beat_ctr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_len,
  input  logic [1:0]        load_burst,
  output logic [ADDR_W-1:0] word_addr,
  output logic              last
);

  logic [ADDR_W-1:0] word_addr_r;
  logic [7:0]        count_r;
  logic [7:0]        len_r;
  logic              incr_r;
  logic              last_r;

  // Load on address handshake, advance one beat per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_addr_r <= {ADDR_W{1'b0}};
      count_r     <= 8'd0;
      len_r       <= 8'd0;
      incr_r      <= 1'b0;
      last_r      <= 1'b0;
    end else if (load) begin
      word_addr_r <= load_addr;
      count_r     <= 8'd0;
      len_r       <= load_len;
      incr_r      <= (load_burst == BURST_INCR);
      last_r      <= (load_len == 8'd0);
    end else if (step) begin
      count_r <= count_r + 8'd1;
      last_r  <= ((count_r + 8'd1) == len_r);
      if (incr_r) begin
        word_addr_r <= word_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        word_addr_r <= word_addr_r;
      end
    end else begin
      word_addr_r <= word_addr_r;
      count_r     <= count_r;
      last_r      <= last_r;
    end
  end

  assign word_addr = word_addr_r;
  assign last      = last_r;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave serving one single/burst transaction at a time onto a 32-bit
// word-addressed synchronous SRAM; writes win arbitration over reads.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   s_awid,
  input  logic [31:0]       s_awaddr,
  input  logic [7:0]        s_awlen,
  input  logic [2:0]        s_awsize,
  input  logic [1:0]        s_awburst,
  input  logic              s_awlock,
  input  logic [3:0]        s_awcache,
  input  logic [2:0]        s_awprot,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wlast,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [ID_W-1:0]   s_bid,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [31:0]       s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  input  logic              s_arlock,
  input  logic [3:0]        s_arcache,
  input  logic [2:0]        s_arprot,
  input  logic [3:0]        s_arqos,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [ID_W-1:0]   s_rid,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [ADDR_W-1:0] memAddress,
  output logic [31:0]       memWriteData,
  output logic [3:0]        memByteEnable,
  output logic              memWriteEnable,
  output logic              memReadEnable,
  input  logic [31:0]       memReadData
);

  state_e            state_r;
  logic [ID_W-1:0]   id_r;
  logic              aerr_r;
  logic              werr_r;
  logic              bvalid_r;
  logic [ID_W-1:0]   bid_r;
  logic [1:0]        bresp_r;
  logic              rvalid_r;
  logic [ID_W-1:0]   rid_r;
  logic [31:0]       rdata_r;
  logic [1:0]        rresp_r;
  logic              rlast_r;

  logic              wr_load_s, rd_load_s, w_hs_s, rd_step_s, wlast_bad_s;
  logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;
  logic              wr_last_s, rd_last_s;
  logic              unused_s;

  assign s_awready = (state_r == ST_IDLE);
  assign s_arready = (state_r == ST_IDLE) && !s_awvalid;
  assign s_wready  = (state_r == ST_W_DATA);

  assign wr_load_s   = (state_r == ST_IDLE) && s_awvalid;
  assign rd_load_s   = (state_r == ST_IDLE) && !s_awvalid && s_arvalid;
  assign w_hs_s      = (state_r == ST_W_DATA) && s_wvalid;
  assign rd_step_s   = rvalid_r && s_rready && !rlast_r;
  assign wlast_bad_s = (s_wlast != wr_last_s);

  // Flagged requests still run their beats but never touch the SRAM.
  assign memWriteEnable = w_hs_s && !aerr_r;
  assign memReadEnable  = (state_r == ST_R_ISSUE) && !aerr_r;
  assign memAddress     = (state_r == ST_W_DATA) ? wr_addr_s : rd_addr_s;
  assign memWriteData   = s_wdata;
  assign memByteEnable  = s_wstrb;

  axi_beat_ctr #(.ADDR_W(ADDR_W)) u_aw_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (wr_load_s),
    .step      (w_hs_s),
    .load_addr (s_awaddr[ADDR_W+1:2]),
    .load_len  (s_awlen),
    .load_burst(s_awburst),
    .word_addr (wr_addr_s),
    .last      (wr_last_s)
  );

  axi_beat_ctr #(.ADDR_W(ADDR_W)) u_ar_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (rd_load_s),
    .step      (rd_step_s),
    .load_addr (s_araddr[ADDR_W+1:2]),
    .load_len  (s_arlen),
    .load_burst(s_arburst),
    .word_addr (rd_addr_s),
    .last      (rd_last_s)
  );

  // Transaction FSM with registered B and R channel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      id_r     <= {ID_W{1'b0}};
      aerr_r   <= 1'b0;
      werr_r   <= 1'b0;
      bvalid_r <= 1'b0;
      bid_r    <= {ID_W{1'b0}};
      bresp_r  <= RESP_OKAY;
      rvalid_r <= 1'b0;
      rid_r    <= {ID_W{1'b0}};
      rdata_r  <= 32'd0;
      rresp_r  <= RESP_OKAY;
      rlast_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (s_awvalid) begin
            id_r    <= s_awid;
            aerr_r  <= addr_error(s_awsize, s_awburst);
            werr_r  <= 1'b0;
            state_r <= ST_W_DATA;
          end else if (s_arvalid) begin
            id_r    <= s_arid;
            aerr_r  <= addr_error(s_arsize, s_arburst);
            state_r <= ST_R_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_W_DATA: begin
          if (s_wvalid) begin
            werr_r <= werr_r || wlast_bad_s;
            if (wr_last_s) begin
              bvalid_r <= 1'b1;
              bid_r    <= id_r;
              bresp_r  <= (aerr_r || werr_r || wlast_bad_s) ? RESP_SLVERR : RESP_OKAY;
              state_r  <= ST_W_RESP;
            end else begin
              state_r <= ST_W_DATA;
            end
          end else begin
            state_r <= ST_W_DATA;
          end
        end
        ST_W_RESP: begin
          if (s_bready) begin
            bvalid_r <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            state_r <= ST_W_RESP;
          end
        end
        ST_R_ISSUE: state_r <= ST_R_WAIT;
        ST_R_WAIT: begin
          rdata_r  <= aerr_r ? 32'd0 : memReadData;
          rresp_r  <= aerr_r ? RESP_SLVERR : RESP_OKAY;
          rid_r    <= id_r;
          rlast_r  <= rd_last_s;
          rvalid_r <= 1'b1;
          state_r  <= ST_R_DATA;
        end
        ST_R_DATA: begin
          if (s_rready) begin
            rvalid_r <= 1'b0;
            state_r  <= rlast_r ? ST_IDLE : ST_R_ISSUE;
          end else begin
            state_r <= ST_R_DATA;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign s_bvalid = bvalid_r;
  assign s_bid    = bid_r;
  assign s_bresp  = bresp_r;
  assign s_rvalid = rvalid_r;
  assign s_rid    = rid_r;
  assign s_rdata  = rdata_r;
  assign s_rresp  = rresp_r;
  assign s_rlast  = rlast_r;

  // Sideband attributes and out-of-range address bits carry no meaning here.
  assign unused_s = ^{s_awaddr[31:ADDR_W+2], s_awaddr[1:0], s_araddr[31:ADDR_W+2],
                      s_araddr[1:0], s_awlock, s_awcache, s_awprot, s_arlock,
                      s_arcache, s_arprot, s_arqos, RESP_DECERR};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave: a behavioural SRAM plus a reference
// word array predicts every response, read word and write pulse count.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  s_awid, s_arid, s_bid, s_rid;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize, s_awprot, s_arprot;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic        s_awlock, s_arlock;
  logic [3:0]  s_awcache, s_arcache, s_arqos, s_wstrb;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [13:0] memAddress;
  logic [31:0] memWriteData, memReadData;
  logic [3:0]  memByteEnable;
  logic        memWriteEnable, memReadEnable;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  logic [13:0] wr_last_addr = 14'd0;

  logic [31:0] sram    [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [31:0] wbuf_data [0:255];
  logic [3:0]  wbuf_strb [0:255];

  logic [1:0]  bresp_o;
  logic [3:0]  bid_o;
  int          wready_lat, b_lat, r_lat_first, rd_gap_bad, rd_stable_bad;
  logic        re_at_t1;
  logic [31:0] rd_data [0:255];
  logic [1:0]  rd_resp [0:255];
  logic        rd_last [0:255];
  logic [3:0]  rd_rid;

  axi_sram_slave dut (
    .clk(clk), .reset(reset),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arqos(s_arqos), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .memAddress(memAddress), .memWriteData(memWriteData), .memByteEnable(memByteEnable),
    .memWriteEnable(memWriteEnable), .memReadEnable(memReadEnable), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM with one-cycle read latency, plus pulse monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (memWriteEnable === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (memByteEnable[b]) sram[memAddress][8*b +: 8] <= memWriteData[8*b +: 8];
      wr_pulses    <= wr_pulses + 1;
      wr_last_addr <= memAddress;
    end
    if (memReadEnable === 1'b1) begin
      memReadData <= sram[memAddress];
      rd_pulses   <= rd_pulses + 1;
    end
  end

  function automatic bit ref_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b010) || (burst > 2'b01);
  endfunction

  function automatic int ref_word(input logic [31:0] addr, input logic [1:0] burst, input int i);
    return (int'(addr[15:2]) + ((burst == 2'b01) ? i : 0)) % 16384;
  endfunction

  task automatic ref_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size);
    int w;
    if (!ref_err(size, burst)) begin
      for (int i = 0; i <= len; i++) begin
        w = ref_word(addr, burst, i);
        for (int b = 0; b < 4; b++)
          if (wbuf_strb[i][b]) ref_mem[w][8*b +: 8] = wbuf_data[i][8*b +: 8];
      end
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic [1:0] burst,
                                           input logic [2:0] size, input int i);
    if (ref_err(size, burst)) return 32'd0;
    return ref_mem[ref_word(addr, burst, i)];
  endfunction

  task automatic timeout(input string what);
    $display("FAIL %s: handshake not seen within 50 cycles (required within 50)", what);
    errors++;
    checks++;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int bad_beat,
                           input bit early_w);
    int n, aw_c;
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1; s_bready = 1'b0;
    if (early_w) begin
      s_wdata = wbuf_data[0]; s_wstrb = wbuf_strb[0];
      s_wlast = (len == 8'd0) ^ (bad_beat == 0); s_wvalid = 1'b1;
    end
    #1; n = 0;
    while (!s_awready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) timeout("aw_wait");
    aw_c = cyc;
    @(posedge clk); @(negedge clk);
    s_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_wdata = wbuf_data[i]; s_wstrb = wbuf_strb[i];
      s_wlast = (i == int'(len)) ^ (i == bad_beat); s_wvalid = 1'b1;
      #1; n = 0;
      while (!s_wready && n < 50) begin @(negedge clk); #1; n++; end
      if (n >= 50) timeout("w_wait");
      if (i == 0) wready_lat = cyc - aw_c;
      @(posedge clk); @(negedge clk);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    #1; n = 0;
    while (!s_bvalid && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) timeout("b_wait");
    b_lat = cyc - aw_c; bresp_o = s_bresp; bid_o = s_bid;
    s_bready = 1'b1;
    @(posedge clk); @(negedge clk);
    s_bready = 1'b0;
    #1;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int stall);
    int n, ar_c, hs_c;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1; s_rready = 1'b0;
    #1; n = 0;
    while (!s_arready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) timeout("ar_wait");
    ar_c = cyc; hs_c = cyc;
    @(posedge clk); @(negedge clk);
    s_arvalid = 1'b0;
    #1;
    re_at_t1 = memReadEnable;
    rd_gap_bad = 0; rd_stable_bad = 0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!s_rvalid && n < 50) begin @(negedge clk); #1; n++; end
      if (n >= 50) timeout("r_wait");
      if (i == 0) r_lat_first = cyc - ar_c;
      else if (cyc - hs_c != 3) rd_gap_bad++;
      rd_data[i] = s_rdata; rd_resp[i] = s_rresp; rd_last[i] = s_rlast; rd_rid = s_rid;
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); @(negedge clk); #1;
        if (s_rvalid !== 1'b1 || s_rdata !== rd_data[i] || s_rlast !== rd_last[i]) rd_stable_bad++;
      end
      s_rready = 1'b1; hs_c = cyc;
      @(posedge clk); @(negedge clk);
      s_rready = 1'b0;
      #1;
    end
  endtask

  task automatic test_reset;
    #1;
    if ({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, memWriteEnable, memReadEnable} !== 7'b1100000) begin
      $display("FAIL reset_ctrl: got %b expected 1100000", {s_awready, s_arready, s_wready, s_bvalid, s_rvalid, memWriteEnable, memReadEnable});
      errors++;
    end
    checks++;
    if ({s_rdata, s_rid, s_bid, s_bresp, s_rresp, s_rlast} !== 45'd0) begin
      $display("FAIL reset_regs: got rdata=%h rid=%h bid=%h bresp=%b rresp=%b expected all 0", s_rdata, s_rid, s_bid, s_bresp, s_rresp);
      errors++;
    end
    checks++;
  endtask

  task automatic test_single;
    logic [3:0] id;
    int p0;
    id = 4'($urandom);
    wbuf_data[0] = 32'hDEADBEEF; wbuf_strb[0] = 4'hF;
    p0 = wr_pulses;
    axi_write(id, 32'h10, 8'd0, 2'b01, 3'b010, -1, 1'b0);
    ref_write(32'h10, 0, 2'b01, 3'b010);
    if (wr_pulses - p0 != 1 || wr_last_addr !== 14'd4) begin
      $display("FAIL single_wr_pulse: got %0d pulses at %0d expected 1 at 4", wr_pulses - p0, wr_last_addr);
      errors++;
    end
    checks++;
    if (bresp_o !== 2'b00 || bid_o !== id) begin
      $display("FAIL single_b: got bresp=%b bid=%h expected 00 %h", bresp_o, bid_o, id);
      errors++;
    end
    checks++;
    if (wready_lat != 1 || b_lat != 2) begin
      $display("FAIL single_wr_latency: got wready=%0d bvalid=%0d expected 1 2", wready_lat, b_lat);
      errors++;
    end
    checks++;
    id = 4'($urandom);
    axi_read(id, 32'h10, 8'd0, 2'b01, 3'b010, 0);
    if (rd_data[0] !== 32'hDEADBEEF || rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00 || rd_rid !== id) begin
      $display("FAIL single_rd: got %h last=%b resp=%b rid=%h expected deadbeef 1 00 %h", rd_data[0], rd_last[0], rd_resp[0], rd_rid, id);
      errors++;
    end
    checks++;
    if (r_lat_first != 3 || re_at_t1 !== 1'b1) begin
      $display("FAIL single_rd_latency: got rvalid=%0d memRE@t+1=%b expected 3 1", r_lat_first, re_at_t1);
      errors++;
    end
    checks++;
  endtask

  task automatic test_incr_burst(input int stall);
    for (int i = 0; i < 4; i++) begin wbuf_data[i] = 32'(i + 1); wbuf_strb[i] = 4'hF; end
    axi_write(4'h3, 32'h20, 8'd3, 2'b01, 3'b010, -1, 1'b0);
    ref_write(32'h20, 3, 2'b01, 3'b010);
    axi_read(4'h5, 32'h20, 8'd3, 2'b01, 3'b010, stall);
    for (int i = 0; i < 4; i++) begin
      if (rd_data[i] !== ref_read(32'h20, 2'b01, 3'b010, i) || rd_last[i] !== (i == 3)) begin
        $display("FAIL incr_beat%0d_stall%0d: got %h last=%b expected %h last=%b", i, stall, rd_data[i], rd_last[i], ref_read(32'h20, 2'b01, 3'b010, i), i == 3);
        errors++;
      end
      checks++;
    end
    if (rd_gap_bad != 0 || rd_stable_bad != 0) begin
      $display("FAIL incr_timing_stall%0d: got %0d gap and %0d stability errors expected 0 0", stall, rd_gap_bad, rd_stable_bad);
      errors++;
    end
    checks++;
  endtask

  task automatic test_fixed;
    int p0;
    for (int i = 0; i < 3; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
    p0 = wr_pulses;
    axi_write(4'h1, 32'h40, 8'd2, 2'b00, 3'b010, -1, 1'b0);
    ref_write(32'h40, 2, 2'b00, 3'b010);
    if (wr_pulses - p0 != 3 || wr_last_addr !== 14'd16) begin
      $display("FAIL fixed_pulses: got %0d at %0d expected 3 at 16", wr_pulses - p0, wr_last_addr);
      errors++;
    end
    checks++;
    axi_read(4'h1, 32'h40, 8'd0, 2'b01, 3'b010, 0);
    if (rd_data[0] !== wbuf_data[2] || rd_data[0] !== ref_read(32'h40, 2'b01, 3'b010, 0)) begin
      $display("FAIL fixed_rd: got %h expected %h", rd_data[0], wbuf_data[2]);
      errors++;
    end
    checks++;
  endtask

  task automatic test_strobes;
    wbuf_data[0] = 32'hFFFFFFFF; wbuf_strb[0] = 4'hF;
    axi_write(4'h2, 32'h80, 8'd0, 2'b01, 3'b010, -1, 1'b0);
    ref_write(32'h80, 0, 2'b01, 3'b010);
    wbuf_data[0] = 32'h11223344; wbuf_strb[0] = 4'b0101;
    axi_write(4'h2, 32'h80, 8'd0, 2'b01, 3'b010, -1, 1'b0);
    ref_write(32'h80, 0, 2'b01, 3'b010);
    axi_read(4'h2, 32'h80, 8'd0, 2'b01, 3'b010, 0);
    if (rd_data[0] !== 32'hFF22FF44) begin
      $display("FAIL strobes: got %h expected ff22ff44", rd_data[0]);
      errors++;
    end
    checks++;
  endtask

  task automatic test_errors;
    int p0, r0;
    wbuf_data[0] = 32'hBAD0BAD0; wbuf_strb[0] = 4'hF;
    p0 = wr_pulses;
    axi_write(4'h6, 32'h10, 8'd0, 2'b01, 3'b001, -1, 1'b0);
    if (bresp_o !== 2'b10 || wr_pulses != p0) begin
      $display("FAIL err_size: got bresp=%b pulses=%0d expected 10 0", bresp_o, wr_pulses - p0);
      errors++;
    end
    checks++;
    for (int i = 0; i < 2; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
    p0 = wr_pulses;
    axi_write(4'h7, 32'h100, 8'd1, 2'b01, 3'b010, 0, 1'b0);
    ref_write(32'h100, 1, 2'b01, 3'b010);
    if (bresp_o !== 2'b10 || wr_pulses - p0 != 2) begin
      $display("FAIL err_wlast: got bresp=%b pulses=%0d expected 10 2", bresp_o, wr_pulses - p0);
      errors++;
    end
    checks++;
    axi_read(4'h7, 32'h100, 8'd1, 2'b01, 3'b010, 0);
    if (rd_data[0] !== ref_read(32'h100, 2'b01, 3'b010, 0) || rd_data[1] !== ref_read(32'h100, 2'b01, 3'b010, 1)) begin
      $display("FAIL err_wlast_data: got %h %h expected %h %h", rd_data[0], rd_data[1], wbuf_data[0], wbuf_data[1]);
      errors++;
    end
    checks++;
    r0 = rd_pulses;
    axi_read(4'h9, 32'h20, 8'd1, 2'b10, 3'b010, 0);
    if (rd_data[0] !== 32'd0 || rd_data[1] !== 32'd0 || rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10 ||
        rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1 || rd_pulses != r0) begin
      $display("FAIL err_wrap: got %h/%b/%b %h/%b/%b re=%0d expected 0/10/0 0/10/1 0", rd_data[0], rd_resp[0], rd_last[0], rd_data[1], rd_resp[1], rd_last[1], rd_pulses - r0);
      errors++;
    end
    checks++;
  endtask

  task automatic test_arbitration;
    wbuf_data[0] = $urandom; wbuf_strb[0] = 4'hF;
    s_arid = 4'hA; s_araddr = 32'h200; s_arlen = 8'd0; s_arsize = 3'b010; s_arburst = 2'b01;
    s_arvalid = 1'b1; s_awvalid = 1'b1;
    #1;
    if (s_awready !== 1'b1 || s_arready !== 1'b0) begin
      $display("FAIL arb_ready: got awready=%b arready=%b expected 1 0", s_awready, s_arready);
      errors++;
    end
    checks++;
    axi_write(4'hB, 32'h200, 8'd0, 2'b01, 3'b010, -1, 1'b0);
    ref_write(32'h200, 0, 2'b01, 3'b010);
    if (s_arready !== 1'b1) begin
      $display("FAIL arb_after_b: got arready=%b expected 1", s_arready);
      errors++;
    end
    checks++;
    axi_read(4'hA, 32'h200, 8'd0, 2'b01, 3'b010, 0);
    if (rd_data[0] !== ref_read(32'h200, 2'b01, 3'b010, 0) || rd_rid !== 4'hA) begin
      $display("FAIL arb_rd: got %h rid=%h expected %h a", rd_data[0], rd_rid, ref_read(32'h200, 2'b01, 3'b010, 0));
      errors++;
    end
    checks++;
  endtask

  task automatic test_reset_mid;
    int n;
    s_arid = 4'h4; s_araddr = 32'h20; s_arlen = 8'd3; s_arsize = 3'b010; s_arburst = 2'b01;
    s_arvalid = 1'b1; s_rready = 1'b0;
    #1; n = 0;
    while (!s_arready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) timeout("rst_ar_wait");
    @(posedge clk); @(negedge clk);
    s_arvalid = 1'b0;
    #1; n = 0;
    while (!s_rvalid && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) timeout("rst_r_wait");
    reset = 1'b1;
    @(negedge clk); #1;
    if (s_rvalid !== 1'b0 || s_awready !== 1'b1 || s_arready !== 1'b1 || memReadEnable !== 1'b0 || s_bvalid !== 1'b0) begin
      $display("FAIL reset_mid: got rvalid=%b awready=%b arready=%b memRE=%b expected 0 1 1 0", s_rvalid, s_awready, s_arready, memReadEnable);
      errors++;
    end
    checks++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  id;
    int p0;
    for (int it = 0; it < 8; it++) begin
      len = 8'($urandom_range(0, 7)); burst = 2'($urandom_range(0, 1)); id = 4'($urandom);
      addr = {16'($urandom), 14'($urandom_range(16370, 16383)), 2'b00};
      if (it % 2 == 0) addr[15:2] = 14'($urandom);
      for (int i = 0; i <= int'(len); i++) begin
        wbuf_data[i] = $urandom; wbuf_strb[i] = 4'($urandom_range(1, 15));
      end
      p0 = wr_pulses;
      axi_write(id, addr, len, burst, 3'b010, -1, 1'($urandom_range(0, 1)));
      ref_write(addr, int'(len), burst, 3'b010);
      if (bresp_o !== 2'b00 || bid_o !== id || wr_pulses - p0 != int'(len) + 1) begin
        $display("FAIL rand%0d_wr: got bresp=%b bid=%h pulses=%0d expected 00 %h %0d", it, bresp_o, bid_o, wr_pulses - p0, id, int'(len) + 1);
        errors++;
      end
      checks++;
      axi_read(id, addr, len, burst, 3'b010, $urandom_range(0, 2));
      for (int i = 0; i <= int'(len); i++) begin
        if (rd_data[i] !== ref_read(addr, burst, 3'b010, i) || rd_last[i] !== (i == int'(len)) || rd_resp[i] !== 2'b00) begin
          $display("FAIL rand%0d_beat%0d: got %h last=%b resp=%b expected %h last=%b resp=00", it, i, rd_data[i], rd_last[i], rd_resp[i], ref_read(addr, burst, 3'b010, i), i == int'(len));
          errors++;
        end
        checks++;
      end
      if (rd_stable_bad != 0 || rd_gap_bad != 0) begin
        $display("FAIL rand%0d_timing: got %0d stability and %0d gap errors expected 0 0", it, rd_stable_bad, rd_gap_bad);
        errors++;
      end
      checks++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ref_mem[i] = 32'd0;
    reset = 1'b1;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'b010; s_awburst = 2'b01;
    s_awlock = 1'b0; s_awcache = 4'h3; s_awprot = 3'b000; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'b010; s_arburst = 2'b01;
    s_arlock = 1'b0; s_arcache = 4'h3; s_arprot = 3'b000; s_arqos = 4'h0;
    s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_single();
    test_incr_burst(0);
    test_incr_burst(5);
    test_fixed();
    test_strobes();
    test_errors();
    test_arbitration();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
